// File: rtl/fft_pkg.sv
// Shared sizes, sequencer state encoding and {imag,real} sample packing for the FFT frame path.
package fft_pkg;

   localparam int WL_DEF   = 16;
   localparam int N_DEF    = 16;
   localparam int LOGN_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   function automatic logic [2*WL_DEF-1:0] pack_iq(input logic [WL_DEF-1:0] im,
                                                   input logic [WL_DEF-1:0] re);
      return {im, re};
   endfunction

   function automatic logic [WL_DEF-1:0] iq_real(input logic [2*WL_DEF-1:0] s);
      return s[WL_DEF-1:0];
   endfunction

   function automatic logic [WL_DEF-1:0] iq_imag(input logic [2*WL_DEF-1:0] s);
      return s[2*WL_DEF-1:WL_DEF];
   endfunction

endpackage

// File: rtl/fft_frame_ram.sv
// One-frame sample store: single write port, registered read port with write-first bypass.
// Only the read register is reset; array contents are undefined after reset.
module fft_frame_ram #(
   parameter int W     = 32,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Bypass covers a sample written in the same cycle the sequencer starts fetching it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    rdata <= '0;
      else if (we && waddr == raddr) rdata <= wdata;
      else                           rdata <= mem[raddr];
   end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: buffers one software-written input frame, streams it to the FFT core on start,
// captures the N output bins for readback and reports busy/done/err.
module fft_frame_ctrl
   import fft_pkg::*;
#(
   parameter int WL   = WL_DEF,
   parameter int N    = N_DEF,
   parameter int LOGN = LOGN_DEF
) (
   input  logic            s_axi_aclk,
   input  logic            s_axi_aresetn,
   input  logic            wr_en,
   input  logic [LOGN-1:0] wr_idx,
   input  logic [2*WL-1:0] wr_data,
   input  logic            start,
   input  logic            clr,
   input  logic [LOGN-1:0] rd_idx,
   output logic [2*WL-1:0] rd_data,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic            core_in_valid,
   input  logic            core_in_ready,
   output logic [2*WL-1:0] core_in_data,
   output logic            core_in_last,
   input  logic            core_out_valid,
   output logic            core_out_ready,
   input  logic [2*WL-1:0] core_out_data,
   input  logic            core_out_last
);

   state_t          state, state_nxt;
   logic [LOGN-1:0] in_cnt, out_cnt, in_rd_addr;
   logic [2*WL-1:0] in_q;
   logic            start_ok, in_hs, out_hs, in_last, out_last, err_set;

   assign start_ok = start && (state == IDLE);
   assign in_hs    = (state == FEED) && core_in_ready;
   assign out_hs   = (state == DRAIN) && core_out_valid;
   assign in_last  = (in_cnt == LOGN'(N - 1));
   assign out_last = (out_cnt == LOGN'(N - 1));

   // Prefetch the sample that will be on core_in_data next cycle so the registered read lines up.
   assign in_rd_addr = start_ok ? '0 : (in_hs ? in_cnt + LOGN'(1) : in_cnt);

   assign core_in_data = (state == FEED) ? in_q : '0;
   assign core_in_last = (state == FEED) && in_last;

   assign err_set = (busy && (start || wr_en)) || (out_hs && (core_out_last != out_last));

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) state <= IDLE;
      else                state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      busy           = 1'b0;
      core_in_valid  = 1'b0;
      core_out_ready = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = FEED;
         FEED: begin
            busy          = 1'b1;
            core_in_valid = 1'b1;
            if (core_in_ready && in_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy           = 1'b1;
            core_out_ready = 1'b1;
            if (core_out_valid && out_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         in_cnt  <= '0;
         out_cnt <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         if (start_ok)   in_cnt <= '0;
         else if (in_hs) in_cnt <= in_cnt + LOGN'(1);

         if (start_ok)    out_cnt <= '0;
         else if (out_hs) out_cnt <= out_cnt + LOGN'(1);

         if (start_ok)              done <= 1'b0;
         else if (out_hs && out_last) done <= 1'b1;
         else if (clr)              done <= 1'b0;

         if (err_set)  err <= 1'b1;
         else if (clr) err <= 1'b0;
      end
   end

   fft_frame_ram #(.W(2*WL), .DEPTH(N), .AW(LOGN)) in_buf (
      .clk   (s_axi_aclk),
      .rst_n (s_axi_aresetn),
      .we    (wr_en && (state == IDLE)),
      .waddr (wr_idx),
      .wdata (wr_data),
      .raddr (in_rd_addr),
      .rdata (in_q)
   );

   fft_frame_ram #(.W(2*WL), .DEPTH(N), .AW(LOGN)) out_buf (
      .clk   (s_axi_aclk),
      .rst_n (s_axi_aresetn),
      .we    (out_hs),
      .waddr (out_cnt),
      .wdata (core_out_data),
      .raddr (rd_idx),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboarded bench for fft_frame_ctrl with a loopback core model.
module tb_fft_frame_ctrl;
   import fft_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en, start, clr;
   logic [3:0]  wr_idx, rd_idx;
   logic [31:0] wr_data, rd_data;
   logic        busy, done, err;
   logic        core_in_valid, core_in_ready, core_in_last;
   logic [31:0] core_in_data;
   logic        core_out_valid, core_out_ready, core_out_last;
   logic [31:0] core_out_data;

   always #5 clk = ~clk;

   fft_frame_ctrl dut (
      .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
      .start(start), .clr(clr), .rd_idx(rd_idx), .rd_data(rd_data),
      .busy(busy), .done(done), .err(err),
      .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
      .core_in_data(core_in_data), .core_in_last(core_in_last),
      .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
      .core_out_data(core_out_data), .core_out_last(core_out_last)
   );

   int          nvec = 0;
   int          nmis = 0;
   logic [31:0] x       [16];
   logic [31:0] exp_bin [16];
   logic [32:0] exp_in_q [$];
   logic [31:0] loop_q   [$];
   logic [31:0] rd_exp_q [$];
   logic [31:0] out_mask = 32'h0;
   int          last_pos = 15;
   int          out_beat = 0;
   int          in_acc   = 0;
   int          pcnt     = 0;
   bit          rdy_toggle = 1'b0;
   bit          hold_pend  = 1'b0;
   logic [31:0] hold_dat;
   bit          rd_fire = 1'b0;
   bit          rd_seen = 1'b0;
   logic [3:0]  rdy_pat = 4'b1001;
   int          cyc;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: sampled on the falling edge, i.e. what the next rising edge will act on.
   always @(negedge clk) begin
      if (rst_n) begin
         if (core_in_valid) begin
            if (hold_pend) chk("in_hold", core_in_data, hold_dat);
            if (core_in_ready) begin
               in_acc++;
               hold_pend = 1'b0;
               loop_q.push_back(core_in_data ^ out_mask);
               if (exp_in_q.size() == 0) chk("in_extra", 1, 0);
               else chk("in_beat", {core_in_last, core_in_data}, exp_in_q.pop_front());
            end else begin
               hold_pend = 1'b1;
               hold_dat  = core_in_data;
            end
         end else hold_pend = 1'b0;
         if (core_out_valid && core_out_ready) begin
            if (loop_q.size() != 0) void'(loop_q.pop_front());
            out_beat++;
         end
         if (rd_seen) begin
            if (rd_exp_q.size() == 0) chk("rd_extra", 1, 0);
            else chk("rd_data", rd_data, rd_exp_q.pop_front());
         end
      end
   end

   always @(posedge clk) rd_seen <= rd_fire;

   // Core model drive: ready pattern and loopback of accepted samples.
   initial begin
      core_in_ready = 1'b0; core_out_valid = 1'b0; core_out_data = '0; core_out_last = 1'b0;
      forever begin
         @(posedge clk); #1;
         pcnt++;
         core_in_ready  = rdy_toggle ? rdy_pat[3 - (pcnt % 4)] : 1'b1;
         core_out_valid = (loop_q.size() != 0);
         core_out_data  = (loop_q.size() != 0) ? loop_q[0] : 32'h0;
         core_out_last  = (out_beat == last_pos);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic write_frame();
      for (int k = 0; k < 16; k++) begin
         wr_en = 1'b1; wr_idx = 4'(k); wr_data = x[k];
         tick();
      end
      wr_en = 1'b0;
   endtask

   task automatic start_frame();
      for (int k = 0; k < 16; k++) begin
         exp_in_q.push_back({(k == 15), x[k]});
         exp_bin[k] = x[k] ^ out_mask;
      end
      out_beat = 0; in_acc = 0; pcnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int c);
      c = 1;
      while (!done && c < 300) begin
         tick();
         c++;
      end
      if (!done) chk("done_timeout", 0, 1);
   endtask

   task automatic rd_one(input int k, input logic [31:0] e);
      rd_idx = 4'(k);
      rd_exp_q.push_back(e);
      rd_fire = 1'b1;
      tick();
      rd_fire = 1'b0;
   endtask

   task automatic read_all();
      for (int k = 0; k < 16; k++) rd_one(k, exp_bin[k]);
      tick();
   endtask

   task automatic pulse_clr();
      clr = 1'b1; tick(); clr = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; start = 1'b0; clr = 1'b0;
      wr_idx = '0; rd_idx = '0; wr_data = '0;
      for (int k = 0; k < 16; k++) x[k] = pack_iq(16'(k), 16'(16'h0100 + k));
      #23;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_in_valid", core_in_valid, 0);
      chk("rst_out_ready", core_out_ready, 0);
      chk("rst_rd_data", rd_data, 0);
      tick(); rst_n = 1'b1; tick();

      // 1: reset in the middle of FEED
      write_frame();
      start_frame();
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      exp_in_q.delete(); loop_q.delete(); hold_pend = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_in_valid", core_in_valid, 0);
      chk("midrst_done", done, 0);
      chk("midrst_err", err, 0);
      tick(); tick(); rst_n = 1'b1; tick();
      chk("postrst_busy", busy, 0);
      chk("postrst_in_valid", core_in_valid, 0);

      // 2: nominal frame, loopback, latency and readback
      write_frame();
      start_frame();
      chk("busy_feed", busy, 1);
      wait_done(cyc);
      chk("latency", cyc, 33);
      chk("done_set", done, 1);
      chk("err_clean", err, 0);
      chk("busy_idle", busy, 0);
      rd_one(7, 32'h0007_0107);
      tick();
      read_all();

      // 3: ready toggling 1,0,0,1
      for (int k = 0; k < 16; k++) x[k] = pack_iq(16'(16'hA000 + k), 16'(16'h5000 + 3 * k));
      write_frame();
      rdy_toggle = 1'b1;
      start_frame();
      wait_done(cyc);
      rdy_toggle = 1'b0;
      chk("toggle_accepted", in_acc, 16);
      chk("toggle_q_empty", exp_in_q.size(), 0);
      chk("toggle_err", err, 0);
      read_all();

      // 4: protocol violations during FEED
      start_frame();
      start = 1'b1; tick(); start = 1'b0;
      chk("err_start_busy", err, 1);
      pulse_clr();
      chk("err_clr", err, 0);
      wr_en = 1'b1; wr_idx = 4'd3; wr_data = 32'hDEAD_BEEF; clr = 1'b1;
      tick();
      wr_en = 1'b0; clr = 1'b0;
      chk("err_set_wins", err, 1);
      wait_done(cyc);
      chk("viol_done", done, 1);
      chk("viol_err", err, 1);
      pulse_clr();
      chk("clr_err", err, 0);
      chk("clr_done", done, 0);
      read_all();
      chk("bin3_kept", exp_bin[3], 32'hA003_5009);

      // 5: early core_out_last
      last_pos = 9;
      start_frame();
      wait_done(cyc);
      last_pos = 15;
      chk("early_last_done", done, 1);
      chk("early_last_err", err, 1);
      pulse_clr();

      // 6: back-to-back frames, second starts the cycle after done
      for (int k = 0; k < 16; k++) x[k] = pack_iq(16'(16'h1230 + k), 16'(16'hFE00 - k));
      write_frame();
      out_mask = 32'hFFFF_FFFF;
      start_frame();
      wait_done(cyc);
      out_mask = 32'h0;
      start_frame();
      chk("b2b_done_clr", done, 0);
      wait_done(cyc);
      chk("b2b_latency", cyc, 33);
      chk("b2b_err", err, 0);
      read_all();
      chk("rd_q_drained", rd_exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

   initial begin
      #400000;
      nmis++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
